// File: rtl/msg_buffer_pkg.sv
// msg_buffer_pkg: shared defaults and parameter checks for msg_buffer.
// Holds default MSG_WIDTH/DEPTH and the DEPTH power-of-two check.
package msg_buffer_pkg;

  localparam int MSG_WIDTH_DEF = 16;
  localparam int DEPTH_DEF     = 32;

  function automatic bit is_pow2(int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/msg_buffer_if.sv
// msg_buffer_if: request/response bundle for msg_buffer.
// master drives flush/wr_en/wr_data/rd_en; slave returns data and status.
interface msg_buffer_if
  import msg_buffer_pkg::*;
#(
  parameter int MSG_WIDTH = MSG_WIDTH_DEF,
  parameter int ADDR_W    = $clog2(DEPTH_DEF)
);

  logic                 flush;
  logic                 wr_en;
  logic [MSG_WIDTH-1:0] wr_data;
  logic                 rd_en;
  logic [MSG_WIDTH-1:0] rd_data;
  logic                 rd_valid;
  logic [ADDR_W:0]      count;
  logic                 full;
  logic                 empty;
  logic                 overflow;
  logic                 underflow;
  logic                 drop;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, count, full, empty,
    input  overflow, underflow, drop
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, count, full, empty,
    output overflow, underflow, drop
  );

endinterface

// File: rtl/msg_buffer_mem.sv
// msg_buffer_mem: simple dual-port storage, one write, one sync read.
// Ports: clk, we_i/waddr_i/wdata_i write, re_i/raddr_i read, rdata_o.
module msg_buffer_mem #(
  parameter int MSG_WIDTH = 16,
  parameter int DEPTH     = 32,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_W-1:0]    waddr_i,
  input  logic [MSG_WIDTH-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_W-1:0]    raddr_i,
  output logic [MSG_WIDTH-1:0] rdata_o
);

  logic [MSG_WIDTH-1:0] mem_q [DEPTH];
  logic [MSG_WIDTH-1:0] rdata_q;

  // Read-before-write: same-address access returns the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/msg_buffer.sv
// msg_buffer: circular message buffer with sticky error flags.
// Ports: clk, rst (sync, active-high), bus (msg_buffer_if.slave).
// Define MSG_BUFFER_OVERWRITE_EN to overwrite the oldest entry when full.
module msg_buffer
  import msg_buffer_pkg::*;
#(
  parameter int MSG_WIDTH = MSG_WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input logic        clk,
  input logic        rst,
  msg_buffer_if.slave bus
);

  if (!is_pow2(DEPTH)) begin : g_depth_chk
    $error("msg_buffer: DEPTH must be a power of two >= 2");
  end

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              drop_q, drop_d;
  logic              rdv_q, rdv_d;
  logic              dok_q, dok_d;

  logic full, empty;
  logic rd_acc, wr_acc, blk, ovw;
  logic mem_we, mem_re;
  logic [MSG_WIDTH-1:0] mem_rdata;

  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);

  assign rd_acc = bus.rd_en && !empty;
  assign wr_acc = bus.wr_en && (!full || rd_acc);
  assign blk    = bus.wr_en && full && !rd_acc;

`ifdef MSG_BUFFER_OVERWRITE_EN
  assign ovw = blk;
`else
  assign ovw = 1'b0;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    dok_d    = dok_q;
    drop_d   = 1'b0;
    rdv_d    = 1'b0;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (bus.rd_en && empty) begin
        unf_d = 1'b1;
      end
      if (rd_acc) begin
        mem_re   = 1'b1;
        rdv_d    = 1'b1;
        dok_d    = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (wr_acc || ovw) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      // Overwrite drops the oldest entry: read side skips it.
      if (ovw) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        drop_d   = 1'b1;
      end
`ifndef MSG_BUFFER_OVERWRITE_EN
      if (blk) begin
        ovf_d = 1'b1;
      end
`endif
      if (wr_acc && !rd_acc) begin
        cnt_d = cnt_q + CNT_ONE;
      end else if (rd_acc && !wr_acc) begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      drop_q   <= 1'b0;
      rdv_q    <= 1'b0;
      dok_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      drop_q   <= drop_d;
      rdv_q    <= rdv_d;
      dok_q    <= dok_d;
    end
  end

  msg_buffer_mem #(
    .MSG_WIDTH(MSG_WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_mem (
    .clk    (clk),
    .we_i   (mem_we && !rst),
    .waddr_i(wr_ptr_q),
    .wdata_i(bus.wr_data),
    .re_i   (mem_re && !rst),
    .raddr_i(rd_ptr_q),
    .rdata_o(mem_rdata)
  );

  // Storage has no reset; rd_data reads as zero until the first read.
  assign bus.rd_data   = dok_q ? mem_rdata : '0;
  assign bus.rd_valid  = rdv_q;
  assign bus.count     = cnt_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.drop      = drop_q;

endmodule

// File: tb/tb_msg_buffer.sv
// tb_msg_buffer: directed plus random checks of msg_buffer against a
// queue-based model of the buffer contract.
module tb_msg_buffer;

  localparam int W  = 16;
  localparam int D  = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  msg_buffer_if #(.MSG_WIDTH(W), .ADDR_W(AW)) bus ();

  msg_buffer #(
    .MSG_WIDTH(W),
    .DEPTH    (D),
    .ADDR_W   (AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [W-1:0] q [$];
  logic [W-1:0] m_rdd;
  bit           m_rdv, m_ovf, m_unf, m_drop;

`ifdef MSG_BUFFER_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(bit r, bit fl, bit w, logic [W-1:0] d, bit rd);
    bit was_full;
    bit rd_ok;
    if (r) begin
      q.delete();
      m_rdd = '0;
      {m_rdv, m_ovf, m_unf, m_drop} = '0;
      return;
    end
    m_rdv  = 1'b0;
    m_drop = 1'b0;
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    was_full = (q.size() == D);
    rd_ok    = rd && (q.size() != 0);
    if (rd && !rd_ok) m_unf = 1'b1;
    if (rd_ok) begin
      m_rdd = q.pop_front();
      m_rdv = 1'b1;
    end
    if (w) begin
      if (!was_full || rd_ok) begin
        q.push_back(d);
      end else if (OVW) begin
        void'(q.pop_front());
        q.push_back(d);
        m_drop = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("full", 32'(bus.full), 32'(q.size() == D));
    chk("empty", 32'(bus.empty), 32'(q.size() == 0));
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    chk("rd_data", 32'(bus.rd_data), 32'(m_rdd));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow), 32'(m_unf));
    chk("drop", 32'(bus.drop), 32'(m_drop));
  endtask

  task automatic step(bit r, bit fl, bit w, logic [W-1:0] d, bit rd);
    @(negedge clk);
    rst         = r;
    bus.flush   = fl;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = rd;
    @(posedge clk);
    model(r, fl, w, d, rd);
    #1;
    check_all();
  endtask

  task automatic wr(logic [W-1:0] d);
    step(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic rdx();
    step(1'b0, 1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] first;
    rst         = 1'b1;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.rd_en   = 1'b0;

    // reset, with requests active to show rst priority
    step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_rd_data", 32'(bus.rd_data), 0);

    // three writes then three reads
    for (int i = 1; i <= 3; i++) wr(W'(i));
    chk("seq_count3", 32'(bus.count), 3);
    for (int i = 1; i <= 3; i++) begin
      rdx();
      chk("seq_rd", 32'(bus.rd_data), 32'(i));
      chk("seq_rdv", 32'(bus.rd_valid), 1);
    end
    idle();
    chk("seq_rdv_drop", 32'(bus.rd_valid), 0);
    chk("seq_hold", 32'(bus.rd_data), 3);
    chk("seq_empty", 32'(bus.empty), 1);

    // fill, one extra write, drain
    for (int i = 0; i < D; i++) wr(W'(16'h0100 + i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_count", 32'(bus.count), D);
    wr(16'hBEEF);
    chk("extra_ovf", 32'(bus.overflow), OVW ? 0 : 1);
    chk("extra_drop", 32'(bus.drop), OVW ? 1 : 0);
    chk("extra_count", 32'(bus.count), D);
    first = OVW ? 16'h0101 : 16'h0100;
    rdx();
    chk("drain_first", 32'(bus.rd_data), 32'(first));
    for (int i = 1; i < D; i++) rdx();
    chk("drain_last", 32'(bus.rd_data), OVW ? 32'hBEEF : 32'h011F);
    chk("drain_empty", 32'(bus.empty), 1);

    // read+write into empty: no bypass
    step(1'b0, 1'b0, 1'b1, 16'h00AA, 1'b1);
    chk("byp_unf", 32'(bus.underflow), 1);
    chk("byp_rdv", 32'(bus.rd_valid), 0);
    chk("byp_count", 32'(bus.count), 1);
    rdx();
    chk("byp_data", 32'(bus.rd_data), 32'h00AA);

    // full with simultaneous read and write
    step(1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < D; i++) wr(W'(16'h0200 + i));
    step(1'b0, 1'b0, 1'b1, 16'h5555, 1'b1);
    chk("fullrw_data", 32'(bus.rd_data), 32'h0200);
    chk("fullrw_count", 32'(bus.count), D);
    chk("fullrw_ovf", 32'(bus.overflow), 0);
    for (int i = 0; i < D; i++) rdx();
    chk("fullrw_last", 32'(bus.rd_data), 32'h5555);

    // flush with rd_en, then wrap traffic
    for (int i = 0; i < 5; i++) wr(W'(16'h0300 + i));
    step(1'b0, 1'b1, 1'b0, '0, 1'b1);
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_rdv", 32'(bus.rd_valid), 0);
    chk("flush_unf", 32'(bus.underflow), 0);
    for (int i = 0; i < 40; i++) begin
      wr(W'(16'h0400 + i));
      rdx();
      chk("wrap_data", 32'(bus.rd_data), 32'(16'h0400 + i));
    end

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit r, fl, w, rd;
      int pw;
      pw = ((i / 250) % 2 == 0) ? 80 : 30;
      r  = ($urandom_range(0, 299) == 0);
      fl = ($urandom_range(0, 79) == 0);
      w  = ($urandom_range(0, 99) < pw);
      rd = ($urandom_range(0, 99) < 50);
      step(r, fl, w, W'($urandom), rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
